// File: rtl/norm_pkg.sv
// Shared definitions for the leading-one normaliser and its consumers
// (the square/div selection logic downstream).
//
// Contents:
//   exp_w_f      - width of the exponent/shift fields for a given word width
//   NORM_DATA_W  - word width used by the standard datapath instance
//   NORM_FRAC_W  - fraction width used by the standard datapath instance
//   norm_res_t   - result record {norm, exp, shift, frac, zero} at the
//                  standard widths, for modules that pass results around
//                  without being parametrised themselves
package norm_pkg;

    // Exponent and shift both range over 0..w-1, so $clog2(w) bits suffice.
    // The floor of 1 keeps the field legal if someone asks about w=1.
    function automatic int exp_w_f(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

    localparam int NORM_DATA_W = 10;
    localparam int NORM_FRAC_W = 2;
    localparam int NORM_EXP_W  = exp_w_f(NORM_DATA_W);

    typedef struct packed {
        logic [NORM_DATA_W-1:0] norm;
        logic [NORM_EXP_W-1:0]  exp;
        logic [NORM_EXP_W-1:0]  shift;
        logic [NORM_FRAC_W-1:0] frac;
        logic                   zero;
    } norm_res_t;

endpackage

// File: rtl/norm_lead_pipe_if.sv
// Handshake bundle for norm_lead_pipe.
//
// Input side : in_valid, in_ready, in_data, in_tag
// Output side: out_valid, out_ready, out_norm, out_exp, out_shift,
//              out_frac, out_zero, out_tag
//
// Handshake: a word moves across a side on a rising clock edge where both
// valid and ready are high. A producer that raises valid keeps valid and its
// payload unchanged until that transfer happens; ready may be high or low
// without regard to valid.
//
// Modports: master = the producer/consumer around the block (drives in_*
// payload and out_ready); slave = the normaliser itself.
interface norm_lead_pipe_if #(
    parameter int DATA_W = 10,
    parameter int FRAC_W = 2,
    parameter int TAG_W  = 4
);
    localparam int EXP_W = norm_pkg::exp_w_f(DATA_W);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_norm;
    logic [EXP_W-1:0]  out_exp;
    logic [EXP_W-1:0]  out_shift;
    logic [FRAC_W-1:0] out_frac;
    logic              out_zero;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_norm, out_exp, out_shift,
               out_frac, out_zero, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_norm, out_exp, out_shift,
               out_frac, out_zero, out_tag
    );

endinterface

// File: rtl/norm_lead_enc.sv
// Combinational leading-one priority encoder.
//
// Ports:
//   data  in   DATA_W  word to scan
//   p     out  EXP_W   index of the highest set bit (0 when data is zero)
//   zero  out  1       data has no set bit
module norm_lead_enc
    import norm_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int EXP_W  = exp_w_f(DATA_W)
) (
    input  logic [DATA_W-1:0] data,
    output logic [EXP_W-1:0]  p,
    output logic              zero
);

    // Scan upward so that a later (higher) set bit overwrites an earlier one:
    // the highest set bit wins.
    always_comb begin
        p    = '0;
        zero = 1'b1;
        for (int i = 0; i < DATA_W; i++) begin
            if (data[i]) begin
                p    = EXP_W'(i);
                zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/norm_lead_pipe.sv
// Two-stage pipelined leading-one normaliser.
//
// Finds the most significant set bit p of each word, shifts the word left
// so that bit lands in the MSB, and returns the exponent p, the shift
// DATA_W-1-p, the FRAC_W bits just below the leading one, a zero flag and
// the word's tag.
//
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous reset, active-high; discards all in-flight words
//   bus  norm_lead_pipe_if.slave
//        in_valid/in_ready/in_data/in_tag        word in
//        out_valid/out_ready/out_norm/out_exp/
//        out_shift/out_frac/out_zero/out_tag     result out
//
// Stage 1 registers the word, tag and encoder result; stage 2 registers the
// shifted word and derived fields. Each stage advances when it is empty or
// the stage after it is advancing, so a bubble in stage 1 is refilled even
// while stage 2 is stalled and up to two words are held. in_ready depends
// on out_ready only; there is no path from in_valid to out_valid.
module norm_lead_pipe
    import norm_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int FRAC_W = 2,
    parameter int TAG_W  = 4
) (
    input  logic           clk,
    input  logic           rst,
    norm_lead_pipe_if.slave bus
);

    localparam int EXP_W = exp_w_f(DATA_W);

    // Same field layout as norm_pkg::norm_res_t, at this instance's widths.
    typedef struct packed {
        logic [DATA_W-1:0] norm;
        logic [EXP_W-1:0]  exp;
        logic [EXP_W-1:0]  shift;
        logic [FRAC_W-1:0] frac;
        logic              zero;
    } res_t;

    // ---------------- stage control ----------------
    logic v1;
    logic v2;
    logic adv1;
    logic adv2;

    assign adv2         = !v2 || bus.out_ready;
    assign adv1         = !v1 || adv2;
    assign bus.in_ready = adv1;

    // ---------------- stage 1 ----------------
    logic [EXP_W-1:0]  enc_p;
    logic              enc_zero;
    logic [DATA_W-1:0] d1;
    logic [TAG_W-1:0]  t1;
    logic [EXP_W-1:0]  p1;
    logic              z1;

    norm_lead_enc #(
        .DATA_W (DATA_W),
        .EXP_W  (EXP_W)
    ) u_enc (
        .data (bus.in_data),
        .p    (enc_p),
        .zero (enc_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            d1 <= '0;
            t1 <= '0;
            p1 <= '0;
            z1 <= 1'b0;
        end else if (adv1) begin
            v1 <= bus.in_valid;
            // Payload only loads with a real word; a bubble leaves it as is.
            if (bus.in_valid) begin
                d1 <= bus.in_data;
                t1 <= bus.in_tag;
                p1 <= enc_p;
                z1 <= enc_zero;
            end
        end
    end

    // ---------------- stage 2 datapath ----------------
    logic [EXP_W-1:0]  shift_c;
    logic [DATA_W-1:0] norm_c;
    res_t              res_next;

    // A zero word reports every field as 0 rather than a shift of DATA_W-1.
    always_comb begin
        shift_c  = '0;
        norm_c   = '0;
        res_next = '0;
        if (!z1) begin
            shift_c        = EXP_W'(DATA_W - 1) - p1;
            norm_c         = d1 << shift_c;
            res_next.norm  = norm_c;
            res_next.exp   = p1;
            res_next.shift = shift_c;
            // Bits just below the leading one, which now sits in the MSB.
            res_next.frac  = norm_c[DATA_W-2 -: FRAC_W];
        end
        res_next.zero = z1;
    end

    // ---------------- stage 2 registers ----------------
    res_t             r2;
    logic [TAG_W-1:0] t2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0;
            r2 <= '0;
            t2 <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                r2 <= res_next;
                t2 <= t1;
            end
        end
    end

    assign bus.out_valid = v2;
    assign bus.out_norm  = r2.norm;
    assign bus.out_exp   = r2.exp;
    assign bus.out_shift = r2.shift;
    assign bus.out_frac  = r2.frac;
    assign bus.out_zero  = r2.zero;
    assign bus.out_tag   = t2;

endmodule

// File: doc/norm_lead_pipe.md
Name: norm_lead_pipe

Overview:
- Parametrised, pipelined leading-one normaliser for the Normalization datapath.
- Finds the most significant set bit of each input word, left-shifts the word so that bit lands in the MSB, and reports three things: the bit index (exponent), the shift amount, and the FRAC_W bits just below the leading one.
- Two registered stages with a valid/ready handshake, full backpressure and a pass-through tag.
- Replaces the single-width combinational determine logic that feeds the square/div selection.

Parameters:
- DATA_W, 10: input word width; legal range >= 2.
- FRAC_W, 2: number of bits taken below the leading one; legal range 1..DATA_W-1.
- TAG_W, 4: width of the sideband tag carried alongside each word.
- EXP_W, $clog2(DATA_W): width of the exponent and shift fields. Derived; do not override.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word this cycle
- in_data  in  DATA_W  word to normalise
- in_tag  in  TAG_W  sideband tag, returned unchanged
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_norm  out  DATA_W  in_data << out_shift
- out_exp  out  EXP_W  index p of the most significant set bit
- out_shift  out  EXP_W  DATA_W-1-p
- out_frac  out  FRAC_W  out_norm[DATA_W-2 -: FRAC_W]
- out_zero  out  1  in_data was all zeros
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset (asynchronous, rst=1): both stage valid flags clear, so out_valid=0. out_norm, out_exp, out_shift, out_frac, out_zero and out_tag all read 0. in_ready=1 from the first cycle after reset deasserts.
- Reset asserted mid-operation discards every in-flight word. Nothing is replayed.
- Transfer rules: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- Stage advance: adv2 = !v2 || out_ready; adv1 = !v1 || adv2; in_ready = adv1. in_ready is combinational from out_ready; no combinational path runs from in_valid to out_valid.
- Stage 1 (on adv1): registers in_data and in_tag, the leading-one index p from a priority encode (highest set bit wins), and a zero flag. v1 <= in_valid.
- Stage 2 (on adv2): registers norm = data << (DATA_W-1-p), exp, shift, frac and tag. v2 <= v1.
- Latency is exactly 2 cycles from input transfer to out_valid with out_ready held high. Throughput is one word per cycle.
- Stall: while out_valid && !out_ready, every stage-2 output holds stable and stage 1 holds if full. in_ready=0 only when both stages are full and out_ready=0.
- Bubbles: a bubble in stage 1 is filled even while stage 2 is stalled, so up to 2 words can be buffered.
- Zero input: out_zero=1 and out_exp=out_shift=out_norm=out_frac=0. The tag passes through normally.
- Exponent range: 0..DATA_W-1. No overflow is possible. If out_zero=0, out_norm[DATA_W-1]=1 always.
- Shift fill: bits vacated by the shift are filled with 0. out_frac never includes the leading one.
- Ordering: strict FIFO; no reordering, no drops, no duplicates.

Decomposition:
- Package norm_pkg holds the EXP_W derivation function and the result struct typedef {norm, exp, shift, frac, zero}. Shared with the downstream square/div logic.
- One sub-module, norm_lead_enc: parametrised combinational priority encoder with DATA_W in and {p, zero} out. Instantiated once, in stage 1.

Test Plan:
- Reset: assert rst mid-stream with 2 words in flight -> out_valid=0 immediately and all outputs read 0. After release, in_ready=1 and no stale word ever appears.
- Basic word, DATA_W=10, in_data=45 (0b0000101101), tag=3 -> 2 cycles later out_exp=5, out_shift=4, out_norm=720, out_frac=2'b01, out_zero=0, out_tag=3.
- Boundaries: in_data=512 -> exp=9, shift=0, norm=512, frac=00. in_data=1 -> exp=0, shift=9, norm=512, frac=00. in_data=3 -> exp=1, shift=8, norm=768, frac=10. in_data=0 -> zero=1 and all other fields 0.
- Streaming: send 20 random words back-to-back with out_ready=1 -> one result per cycle, in order, each matching the scoreboard model.
- Backpressure: hold out_ready=0 for 5 cycles while feeding words -> exactly 2 accepted, in_ready drops to 0 and outputs stay stable. Releasing out_ready drains both words in order with no loss.
- Parameter sweep: DATA_W=16, FRAC_W=3, in_data=0x0123 -> exp=8, shift=7, norm=0x9180, frac=3'b001.
